// File: rtl/maj_bist_pkg.sv
// rtl/maj_bist_pkg.sv - shared types and constants for the majority-gate BIST controller
package maj_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int                LFSR_W    = 64;
    // Taps 64,63,61,60 expressed as bit positions 63,62,60,59
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int                ERR_W     = 16;
    localparam logic [ERR_W-1:0]  ERR_SAT   = 16'hFFFF;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/maj_bist_ctrl_if.sv
// rtl/maj_bist_ctrl_if.sv - control, result and DUT-stimulus signals of maj_bist_ctrl
interface maj_bist_ctrl_if #(
    parameter int N = 47
);
    import maj_bist_pkg::*;

    logic             start;
    logic [63:0]      seed;
    logic [31:0]      num_vec;
    logic [N-1:0]     dut_x;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [N-1:0]     first_fail_vec;

    modport master (
        output start, seed, num_vec, dut_y,
        input  dut_x, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, seed, num_vec, dut_y,
        output dut_x, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

endinterface

// File: rtl/maj_ref_popcount.sv
// rtl/maj_ref_popcount.sv - golden majority: popcount of x compared against (N+1)/2
module maj_ref_popcount #(
    parameter int N = 47
) (
    input  logic [N-1:0] x,
    output logic         maj_ref
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(x[i]);
        end
    end

    assign maj_ref = (cnt >= CW'((N + 1) / 2));

endmodule

// File: rtl/maj_bist_ctrl.sv
// rtl/maj_bist_ctrl.sv - BIST sequencer for an N-input majority gate; MAJ_BIST_LFSR_EN selects LFSR vectors over a counter
module maj_bist_ctrl
    import maj_bist_pkg::*;
#(
    parameter int N          = 47,
    parameter int SETTLE_CYC = 1
) (
    input logic           clk,
    input logic           rst_n,
    maj_bist_ctrl_if.slave bus
);
`ifdef MAJ_BIST_LFSR_EN
    localparam int GW = LFSR_W;
`else
    localparam int GW = N;
`endif

    state_t           state_q, state_d;
    logic [GW-1:0]    gen_q, gen_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      wait_q, wait_d;
    logic [N-1:0]     dut_x_q, dut_x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [N-1:0]     ffvec_q, ffvec_d;

    logic             maj_ref;
    logic             mismatch;
    logic [GW-1:0]    gen_seed;
    logic [GW-1:0]    gen_next;

    maj_ref_popcount #(.N(N)) u_ref (
        .x       (dut_x_q),
        .maj_ref (maj_ref)
    );

`ifdef MAJ_BIST_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed starts from all-ones
    assign gen_seed = (bus.seed == '0) ? '1 : bus.seed;
    assign gen_next = lfsr_step(gen_q);
`else
    logic unused_seed_hi;
    assign unused_seed_hi = ^bus.seed[63:N];
    assign gen_seed       = bus.seed[N-1:0];
    assign gen_next       = gen_q + GW'(1);
`endif

    assign mismatch = (state_q == ST_CHECK) && (bus.dut_y != maj_ref);

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        dut_x_d = dut_x_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.num_vec;
                    gen_d   = gen_seed;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    if (bus.num_vec == 32'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                dut_x_d = gen_q[N-1:0];
                wait_d  = 32'(SETTLE_CYC);
                state_d = (SETTLE_CYC > 0) ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (wait_q <= 32'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            ST_CHECK: begin
                gen_d = gen_next;
                rem_d = rem_q - 32'd1;
                if (mismatch) begin
                    if (err_q != ERR_SAT) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = dut_x_q;
                    end
                end
                // pass is resolved here so it is valid alongside the done pulse
                if (rem_q == 32'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gen_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            dut_x_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            dut_x_q <= dut_x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign bus.dut_x            = dut_x_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// tb/tb_maj_bist_ctrl.sv - randomized self-checking bench for maj_bist_ctrl against a vector-level model
module tb_maj_bist_ctrl;

    localparam int N = 47;
    localparam int S = 1;
    localparam int P = 2 + S;
    localparam logic [63:0] NMASK = (64'd1 << N) - 64'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   fault_mode = 0;
    logic [2:0] flip_key = 3'd0;

    always #5 clk = ~clk;

    maj_bist_ctrl_if #(.N(N)) bus ();

    maj_bist_ctrl #(.N(N), .SETTLE_CYC(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic maj(input logic [N-1:0] x);
        return $countones(x) >= (N + 1) / 2;
    endfunction

    // 0: healthy gate, 1: stuck-at-0, 2: output inverted whenever x[2:0] equals the key
    function automatic logic dut_model(input logic [N-1:0] x, input int fm, input logic [2:0] key);
        case (fm)
            0:       return maj(x);
            1:       return 1'b0;
            default: return maj(x) ^ (x[2:0] == key);
        endcase
    endfunction

    always_comb bus.dut_y = dut_model(bus.dut_x, fault_mode, flip_key);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] gen_init(input logic [63:0] sd);
`ifdef MAJ_BIST_LFSR_EN
        return (sd == 64'd0) ? '1 : sd;
`else
        return sd & NMASK;
`endif
    endfunction

    function automatic logic [63:0] gen_next(input logic [63:0] g);
`ifdef MAJ_BIST_LFSR_EN
        return {g[62:0], g[63] ^ g[62] ^ g[60] ^ g[59]};
`else
        return (g + 64'd1) & NMASK;
`endif
    endfunction

    task automatic run_case(input string name, input logic [63:0] sd, input int n, input int fm,
                            input logic [2:0] key, input bit poke, input int abort_cyc);
        logic [N-1:0] exp_vec[$];
        logic [63:0]  g;
        logic [N-1:0] x;
        int           exp_err;
        bit           exp_ffv;
        logic [N-1:0] exp_ffvec;
        int           done_cyc, pulses, busy_cyc, vi;
        bit           aborted;

        fault_mode = fm;
        flip_key   = key;
        g          = gen_init(sd);
        exp_err    = 0;
        exp_ffv    = 0;
        exp_ffvec  = '0;
        for (int i = 0; i < n; i++) begin
            x = g[N-1:0];
            exp_vec.push_back(x);
            if (dut_model(x, fm, key) != maj(x)) begin
                if (exp_err < 65535) exp_err++;
                if (!exp_ffv) begin
                    exp_ffv   = 1;
                    exp_ffvec = x;
                end
            end
            g = gen_next(g);
        end

        @(negedge clk);
        bus.seed    = sd;
        bus.num_vec = n;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        done_cyc = -1;
        pulses   = 0;
        busy_cyc = 0;
        vi       = 0;
        aborted  = 0;
        for (int c = 1; c <= P * n + 4; c++) begin
            if (abort_cyc != 0 && c == abort_cyc + 1) begin
                rst_n = 1'b1;
                check({name, " rst busy"}, 64'(bus.busy), 64'd0);
                check({name, " rst dut_x"}, 64'(bus.dut_x), 64'd0);
                check({name, " rst err"}, 64'(bus.err_count), 64'd0);
                check({name, " rst ffv"}, 64'(bus.first_fail_valid), 64'd0);
                aborted = 1;
                break;
            end
            if (poke) begin
                bus.start   = (c == 3 || c == 10);
                bus.seed    = {$urandom, $urandom};
                bus.num_vec = 3;
            end
            if (bus.done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.busy) busy_cyc++;
            if (c % P == 2 && vi < n) begin
                check($sformatf("%s vec%0d", name, vi), 64'(bus.dut_x), 64'(exp_vec[vi]));
                vi++;
            end
            if (abort_cyc != 0 && c == abort_cyc) rst_n = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;

        if (aborted) begin
            for (int c = 0; c < 6; c++) begin
                if (bus.done) pulses++;
                @(posedge clk);
                #1;
            end
            check({name, " no done"}, 64'(pulses), 64'd0);
        end else begin
            check({name, " done cyc"}, 64'(done_cyc), 64'(P * n + 1));
            check({name, " done pulses"}, 64'(pulses), 64'd1);
            check({name, " busy cycles"}, 64'(busy_cyc), 64'(P * n + 1));
            check({name, " pass"}, 64'(bus.pass), 64'(exp_err == 0));
            check({name, " err"}, 64'(bus.err_count), 64'(exp_err));
            check({name, " ffv"}, 64'(bus.first_fail_valid), 64'(exp_ffv));
            check({name, " ffvec"}, 64'(bus.first_fail_vec), 64'(exp_ffvec));
        end
    endtask

    initial begin
        logic [63:0] sd;
        bus.start   = 1'b0;
        bus.seed    = '0;
        bus.num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset pass", 64'(bus.pass), 64'd0);
        check("reset err", 64'(bus.err_count), 64'd0);
        check("reset dut_x", 64'(bus.dut_x), 64'd0);
        check("reset ffv", 64'(bus.first_fail_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_case("basic", 64'd0, 16, 0, 3'd0, 0, 0);
        run_case("stuck0", (64'd1 << N) - 64'd4, 8, 1, 3'd0, 0, 0);
        run_case("zero", 64'd0, 0, 0, 3'd0, 0, 0);
        run_case("poke", 64'd0, 16, 0, 3'd0, 1, 0);
        run_case("abort", (64'd1 << N) - 64'd10, 10, 1, 3'd0, 0, 17);
        run_case("after", 64'd5, 4, 0, 3'd0, 0, 0);
        run_case("flip", 64'd100, 20, 2, 3'd4, 0, 0);

        for (int r = 0; r < 14; r++) begin
            if ($urandom_range(0, 1) == 1) sd = {$urandom, $urandom};
            else sd = (64'd1 << N) - 64'($urandom_range(1, 20));
            run_case($sformatf("rand%0d", r), sd, int'($urandom_range(0, 30)),
                     int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maj_bist_ctrl.md
MAJ_BIST_CTRL -- requirements
Module: maj_bist_ctrl

Interface
REQ-001 Parameter N, default 47, majority DUT input width; odd, 3..63.
REQ-002 Parameter SETTLE_CYC, default 1, wait cycles between driving a vector and sampling dut_y; 0 legal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 seed  input  64  initial vector-generator state, captured on accepted start.
REQ-007 num_vec  input  32  vectors to apply, captured on accepted start.
REQ-008 dut_x  output  N  registered stimulus to the combinational majority DUT.
REQ-009 dut_y  input  1  DUT majority output.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at run end.
REQ-012 pass  output  1  run result, held until next accepted start.
REQ-013 err_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-014 first_fail_valid  output  1  high once any mismatch recorded this run.
REQ-015 first_fail_vec  output  N  dut_x value of first mismatch.

Function
REQ-016 FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-017 IDLE: start=1 captures seed/num_vec, clears err_count, pass, first_fail_*, goes to DRIVE (or DONE if num_vec=0).
REQ-018 DRIVE (1 cycle): dut_x <= current generator value; to WAIT if SETTLE_CYC>0 else CHECK.
REQ-019 WAIT: exactly SETTLE_CYC cycles, then CHECK.
REQ-020 CHECK (1 cycle): ref = (popcount(dut_x) >= (N+1)/2); mismatch if dut_y != ref; generator advances; remaining count decrements; to DONE when remaining reaches 0, else DRIVE.
REQ-021 Per-vector cost 2+SETTLE_CYC cycles; with start accepted at edge E0, done is high in cycle (2+SETTLE_CYC)*num_vec+1 after E0.
REQ-022 Mismatch: err_count increments unless already 16'hFFFF; on first mismatch only, first_fail_vec <= dut_x and first_fail_valid <= 1.
REQ-023 DONE (1 cycle): done=1, pass <= (err_count==0 and no mismatch in final CHECK), then IDLE.
REQ-024 start while busy ignored; no capture, no restart.
REQ-025 dut_x holds last driven vector in IDLE/DONE.

Reset
REQ-026 rst_n=0 at an edge, any state: next state IDLE; dut_x=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, generator=0, remaining=0.
REQ-027 Reset mid-run aborts without done pulse; next start runs from fresh seed.

Configuration
REQ-028 Macro MAJ_BIST_LFSR_EN defined: generator is 64-bit Fibonacci LFSR, taps 64,63,61,60, shift one step per CHECK; vector = low N bits; seed=0 loads all-ones.
REQ-029 MAJ_BIST_LFSR_EN undefined: generator is N-bit up-counter loaded with seed[N-1:0], +1 per CHECK, wraps modulo 2^N.

Structure
REQ-030 Package maj_bist_pkg holds FSM state enum, LFSR width/tap constant, err_count width, saturation value.
REQ-031 Sub-module maj_ref_popcount: combinational N-bit popcount plus threshold compare producing ref.

Verification
REQ-032 N=47, counter mode, SETTLE_CYC=1, seed=0, num_vec=16, correct DUT -> dut_x 0..15 in order, done at cycle 49, pass=1, err_count=0.
REQ-033 N=3, counter mode, seed=0, num_vec=8, DUT stuck-at-0 -> err_count=4, first_fail_vec=3'b011, first_fail_valid=1, pass=0.
REQ-034 num_vec=0 -> done at cycle 1, busy high one cycle, pass=1, err_count=0.
REQ-035 rst_n low one cycle during 6th vector -> next cycle busy=0, dut_x=0, err_count=0, no done; new start with num_vec=4 completes, pass=1.
REQ-036 MAJ_BIST_LFSR_EN defined, N=47, seed=0, num_vec=1 -> dut_x=47'h7FFF_FFFF_FFFF, ref=1, correct DUT gives pass=1.
REQ-037 start pulsed at cycles 3 and 10 of a 16-vector run -> ignored; single done at cycle 49.
